sb_sh_store_scheduler: RTL and testbench
========================================

Name: sb_sh_store_scheduler

Overview:
- Executes sub-word stores SB (op 6'b101000) and SH (op 6'b101001); the main control decoder does not handle these two opcodes.
- Each store is a read-modify-write on the 32-bit word-addressed data memory bus: read the containing word, merge the byte/halfword from rt, write the word back.
- Sits between the execute stage and the data memory port.
- Holds `stall` high so the pipeline freezes until the store completes.

Parameters:
- TIMEOUT, 16: maximum consecutive cycles waitrequest may stay high in one bus phase before the operation is aborted with an error.
- CNT_W, 5: width of the wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  store request valid from execute stage
- op  in  6  opcode of requesting instruction; only 101000 (SB) and 101001 (SH) are legal
- addr  in  32  effective byte address (base + offset)
- rt_data  in  32  store source register value
- mem_readdata  in  32  memory read data
- mem_waitrequest  in  1  memory busy; current bus phase must be held
- mem_address  out  32  word-aligned bus address, {addr[31:2],2'b00}
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_writedata  out  32  merged word
- stall  out  1  pipeline freeze
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset values: state IDLE; mem_read, mem_write, done, err = 0; mem_address, mem_writedata = 0; wait counter = 0.
- Reset mid-operation: return to IDLE on the next edge; strobes are low in the following cycle; the in-flight store is lost.
- States: IDLE, READ, WRITE, DONE.
- IDLE, start=1 with legal op:
  - Latch op, addr[1:0], word address and rt_data.
  - If SH and addr[0]=1: go to DONE with err pending; no bus access.
  - Otherwise go to READ.
- IDLE, start=1 with illegal op: go to DONE with err pending.
- start is ignored outside IDLE.
- READ: mem_read=1.
  - If waitrequest=0 at the edge: capture mem_readdata, build the merged word, go to WRITE.
  - If waitrequest=1: counter increments; if the counter reaches TIMEOUT, go to DONE with err.
- Merge (little-endian lanes, byte offset k occupies bits [8k+7:8k]):
  - SB: lane addr[1:0] := rt_data[7:0]; other lanes keep readdata.
  - SH: addr[1]=0 gives bits[15:0] := rt_data[15:0]; addr[1]=1 gives bits[31:16] := rt_data[15:0].
- WRITE: mem_write=1, mem_writedata=merged word, held stable.
  - waitrequest=0 at the edge: go to DONE.
  - Timeout handled as in READ.
- DONE: done=1 for one cycle, err=1 if pending; strobes low; go to IDLE.
- Counter clears on every state change.
- Never assert mem_read and mem_write together.
- stall = (state==IDLE && start) || state==READ || state==WRITE. stall is low in DONE so the pipeline advances that cycle.
- Latency with zero wait states: start at cycle 0, READ at cycle 1, WRITE at cycle 2, DONE at cycle 3. stall is high in cycles 0–2.
- mem_address is held constant from READ through WRITE.

Optional Feature:
- Macro STORE_BYTEENABLE_EN.
- When defined:
  - Adds output mem_byteenable[3:0].
  - READ is skipped: IDLE goes directly to WRITE.
  - mem_writedata = rt byte/halfword replicated into the target lane(s).
  - byteenable = 4'b0001<<addr[1:0] for SB; 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1) for SH.
  - Zero-wait latency: DONE at cycle 2.
- When undefined: no mem_byteenable port; full read-modify-write as above.

Test Plan:
- SB, addr=0x1003, rt=0x000000AB, readdata=0x11223344, no waits -> read at 0x1000, then write 0xAB223344; done at cycle 3; stall high in cycles 0–2.
- SH, addr=0x2002, rt=0x0000BEEF, readdata=0xDEADC0DE -> write 0xBEEFC0DE at 0x2000; SH at addr=0x2000 with the same data -> 0xDEADBEEF.
- SH, addr=0x2001 -> no read/write strobes; done=err=1 at cycle 1; stall low from cycle 1.
- SB with waitrequest high for 3 cycles in READ and 2 in WRITE -> address/data held stable; done at cycle 8; err=0.
- waitrequest stuck high with TIMEOUT=16 -> READ held 16 cycles, then done=err=1; no write strobe ever issued.
- reset asserted during WRITE -> next cycle mem_write=0, stall=0, state IDLE; a new SB immediately after completes normally.

Source files
------------

// File: rtl/sb_sh_store_scheduler.sv
// sb_sh_store_scheduler
//
// Executes the sub-word stores SB (op 101000) and SH (op 101001) that the
// main control decoder leaves unhandled. Each store is a read-modify-write
// of the containing 32-bit word on the word-addressed data memory bus. The
// pipeline is frozen through `stall` until the store has finished.
//
// Optional build macro: STORE_BYTEENABLE_EN
//   Defined   : adds mem_byteenable[3:0], skips the read phase and writes the
//               replicated rt lane(s) with a byte-enable mask.
//   Undefined : full read-modify-write, no mem_byteenable port.
//
// Parameters
//   TIMEOUT  max consecutive waitrequest cycles in one bus phase before abort
//   CNT_W    width of the wait counter (must hold TIMEOUT)
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start, op          store request and opcode from the execute stage
//   addr, rt_data      effective byte address and store source value
//   mem_readdata       memory read data
//   mem_waitrequest    memory busy; current bus phase is held
//   mem_address        word-aligned bus address
//   mem_read/mem_write bus strobes (never both high)
//   mem_writedata      word written back
//   mem_byteenable     lane mask (STORE_BYTEENABLE_EN only)
//   stall              pipeline freeze
//   done, err          one-cycle completion pulse / coincident error pulse

module sb_sh_store_scheduler #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] rt_data,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
`ifdef STORE_BYTEENABLE_EN
    output logic [3:0]  mem_byteenable,
`endif
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             err_pend;
    logic             err_pend_next;

    logic             op_legal;
    logic             misaligned;
    logic             accept;

    assign op_legal   = (op == OP_SB) || (op == OP_SH);
    assign misaligned = (op == OP_SH) && addr[0];
    // A request is taken (operands latched) whenever a legal op arrives in IDLE.
    assign accept     = (state == IDLE) && start && op_legal;

`ifndef STORE_BYTEENABLE_EN
    logic        is_sh;
    logic [1:0]  lane;
    logic [15:0] rt_q;
    logic [31:0] merged;
`endif

    // Inputs that carry no information for this block.
    logic unused_inputs;
`ifdef STORE_BYTEENABLE_EN
    assign unused_inputs = ^{rt_data[31:16], mem_readdata};
`else
    assign unused_inputs = ^rt_data[31:16];
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            err_pend <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            err_pend <= err_pend_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        err_pend_next = err_pend;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        stall         = 1'b0;
        done          = 1'b0;
        err           = 1'b0;

        case (state)
            IDLE: begin
                err_pend_next = 1'b0;
                if (start) begin
                    stall = 1'b1;
                    if (!op_legal || misaligned) begin
                        state_next    = DONE;
                        err_pend_next = 1'b1;
                    end else begin
`ifdef STORE_BYTEENABLE_EN
                        state_next = WRITE;
`else
                        state_next = READ;
`endif
                    end
                end
            end

            READ: begin
                mem_read = 1'b1;
                stall    = 1'b1;
                if (!mem_waitrequest) begin
                    state_next = WRITE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th consecutive busy cycle.
                    state_next    = DONE;
                    err_pend_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            WRITE: begin
                mem_write = 1'b1;
                stall     = 1'b1;
                if (!mem_waitrequest) begin
                    state_next = DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_next    = DONE;
                    err_pend_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            DONE: begin
                done       = 1'b1;
                err        = err_pend;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next != state) begin
            cnt_next = '0;
        end
    end

`ifndef STORE_BYTEENABLE_EN
    // ------------------------------------------------------------------
    // Lane merge of the store data into the word just read
    // ------------------------------------------------------------------
    always_comb begin
        merged = mem_readdata;
        if (is_sh) begin
            if (lane[1]) begin
                merged[31:16] = rt_q;
            end else begin
                merged[15:0]  = rt_q;
            end
        end else begin
            case (lane)
                2'd0:    merged[7:0]   = rt_q[7:0];
                2'd1:    merged[15:8]  = rt_q[7:0];
                2'd2:    merged[23:16] = rt_q[7:0];
                default: merged[31:24] = rt_q[7:0];
            endcase
        end
    end
`endif

    // ------------------------------------------------------------------
    // Operand latch and bus datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_address    <= '0;
            mem_writedata  <= '0;
`ifdef STORE_BYTEENABLE_EN
            mem_byteenable <= '0;
`else
            is_sh          <= 1'b0;
            lane           <= '0;
            rt_q           <= '0;
`endif
        end else begin
            if (accept) begin
                mem_address <= {addr[31:2], 2'b00};
`ifdef STORE_BYTEENABLE_EN
                if (op == OP_SH) begin
                    mem_writedata  <= {2{rt_data[15:0]}};
                    mem_byteenable <= addr[1] ? 4'b1100 : 4'b0011;
                end else begin
                    mem_writedata  <= {4{rt_data[7:0]}};
                    mem_byteenable <= 4'b0001 << addr[1:0];
                end
`else
                is_sh <= (op == OP_SH);
                lane  <= addr[1:0];
                rt_q  <= rt_data[15:0];
`endif
            end
`ifndef STORE_BYTEENABLE_EN
            // Write data is fixed when the read completes and held through WRITE.
            if ((state == READ) && !mem_waitrequest) begin
                mem_writedata <= merged;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sb_sh_store_scheduler.sv
// Scoreboard bench for sb_sh_store_scheduler (default build).
// Stimulus pushes expected bus/completion events; a monitor pops and
// compares them as the DUT presents them.

module tb_sb_sh_store_scheduler;

    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_BAD = 6'b100011;

    localparam int EV_R = 0;
    localparam int EV_W = 1;
    localparam int EV_D = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rt_data;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        stall;
    logic        done;
    logic        err;

    sb_sh_store_scheduler #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .op              (op),
        .addr            (addr),
        .rt_data         (rt_data),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .stall           (stall),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } ev_t;

    ev_t sb[$];

    int checks   = 0;
    int failures = 0;

    int rd_waits = 0;
    int wr_waits = 0;
    int rd_seen  = 0;
    int wr_seen  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic pop_ev(input int kind, input string nm, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{kind: -1, addr: '0, data: '0, err: 1'b0, cyc: 0};
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected event kind=%0d, scoreboard empty (t=%0t)", nm, kind, $time);
        end else if (sb[0].kind != kind) begin
            checks++;
            failures++;
            $display("FAIL %s event kind actual=%0d expected=%0d (t=%0t)", nm, kind, sb[0].kind, $time);
            void'(sb.pop_front());
        end else begin
            e  = sb.pop_front();
            ok = 1'b1;
        end
    endtask

    // Memory responder: holds waitrequest for a programmed number of cycles per phase.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_read) begin
                if (rd_seen < rd_waits) begin
                    mem_waitrequest = 1'b1;
                    rd_seen++;
                end else begin
                    mem_waitrequest = 1'b0;
                end
            end else if (mem_write) begin
                if (wr_seen < wr_waits) begin
                    mem_waitrequest = 1'b1;
                    wr_seen++;
                end else begin
                    mem_waitrequest = 1'b0;
                end
            end else begin
                mem_waitrequest = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        ev_t e;
        bit  ok;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                chk("strobe_excl", {31'b0, mem_read & mem_write}, 32'd0);
                if (mem_read || mem_write) chk("stall_busy", {31'b0, stall}, 32'd1);
                if (mem_read && mem_waitrequest && sb.size() != 0 && sb[0].kind == EV_R)
                    chk("rd_addr_hold", mem_address, sb[0].addr);
                if (mem_write && mem_waitrequest && sb.size() != 0 && sb[0].kind == EV_W) begin
                    chk("wr_addr_hold", mem_address, sb[0].addr);
                    chk("wr_data_hold", mem_writedata, sb[0].data);
                end
                if (mem_read && !mem_waitrequest) begin
                    pop_ev(EV_R, "read", e, ok);
                    if (ok) chk("rd_addr", mem_address, e.addr);
                end
                if (mem_write && !mem_waitrequest) begin
                    pop_ev(EV_W, "write", e, ok);
                    if (ok) begin
                        chk("wr_addr", mem_address, e.addr);
                        chk("wr_data", mem_writedata, e.data);
                    end
                end
                if (done) begin
                    pop_ev(EV_D, "done", e, ok);
                    if (ok) begin
                        chk("done_err", {31'b0, err}, {31'b0, e.err});
                        chk("done_cycle", cyc - e.cyc, 32'(0));
                        chk("done_stall", {31'b0, stall}, 32'd0);
                    end
                end else begin
                    chk("err_without_done", {31'b0, err}, 32'd0);
                end
            end
        end
    end

    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] rt,
                         input logic [31:0] rd, input int rw, input int ww,
                         input bit has_rw, input logic [31:0] wdata,
                         input bit e_err, input int lat);
        int t0;
        @(negedge clk);
        mem_readdata = rd;
        rd_waits = rw;
        wr_waits = ww;
        rd_seen  = 0;
        wr_seen  = 0;
        op       = o;
        addr     = a;
        rt_data  = rt;
        start    = 1'b1;
        t0       = cyc;
        if (has_rw) begin
            sb.push_back('{kind: EV_R, addr: {a[31:2], 2'b00}, data: '0, err: 1'b0, cyc: 0});
            sb.push_back('{kind: EV_W, addr: {a[31:2], 2'b00}, data: wdata, err: 1'b0, cyc: 0});
        end
        sb.push_back('{kind: EV_D, addr: '0, data: '0, err: e_err, cyc: t0 + lat});
        #1;
        chk("stall_cycle0", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        #3;
        chk("idle_stall", {31'b0, stall}, 32'd0);
    endtask

    task automatic run(input logic [5:0] o, input logic [31:0] a, input logic [31:0] rt,
                       input logic [31:0] rd, input int rw, input int ww,
                       input bit has_rw, input logic [31:0] wdata,
                       input bit e_err, input int lat);
        issue(o, a, rt, rd, rw, ww, has_rw, wdata, e_err, lat);
        drain(60);
    endtask

    initial begin
        int n;
        reset           = 1'b1;
        start           = 1'b0;
        op              = '0;
        addr            = '0;
        rt_data         = '0;
        mem_readdata    = '0;
        mem_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_read",  {31'b0, mem_read},  32'd0);
        chk("rst_write", {31'b0, mem_write}, 32'd0);
        chk("rst_done",  {31'b0, done},      32'd0);
        chk("rst_err",   {31'b0, err},       32'd0);
        chk("rst_stall", {31'b0, stall},     32'd0);
        chk("rst_addr",  mem_address,        32'd0);
        chk("rst_wdata", mem_writedata,      32'd0);
        reset = 1'b0;

        // SB / SH read-modify-write, no waits
        run(OP_SB, 32'h0000_1003, 32'h0000_00AB, 32'h1122_3344, 0, 0, 1, 32'hAB22_3344, 0, 3);
        run(OP_SH, 32'h0000_2002, 32'h0000_BEEF, 32'hDEAD_C0DE, 0, 0, 1, 32'hBEEF_C0DE, 0, 3);
        run(OP_SH, 32'h0000_2000, 32'h0000_BEEF, 32'hDEAD_C0DE, 0, 0, 1, 32'hDEAD_BEEF, 0, 3);
        run(OP_SB, 32'h0000_4000, 32'h0000_005A, 32'hFFFF_FFFF, 0, 0, 1, 32'hFFFF_FF5A, 0, 3);
        run(OP_SB, 32'h0000_4002, 32'h0000_005A, 32'hFFFF_FFFF, 0, 0, 1, 32'hFF5A_FFFF, 0, 3);
        // Misaligned SH and illegal op: error with no bus access
        run(OP_SH, 32'h0000_2001, 32'h0000_BEEF, 32'hDEAD_C0DE, 0, 0, 0, 32'h0, 1, 1);
        run(OP_BAD, 32'h0000_2000, 32'h0000_BEEF, 32'hDEAD_C0DE, 0, 0, 0, 32'h0, 1, 1);
        // Wait states: 3 in READ, 2 in WRITE
        run(OP_SB, 32'h0000_3001, 32'h1234_5678, 32'hAABB_CCDD, 3, 2, 1, 32'hAABB_78DD, 0, 8);
        // waitrequest stuck in READ: abort after 16 busy cycles, never write
        run(OP_SB, 32'h0000_7000, 32'h0000_0011, 32'h0000_0000, 1000, 0, 0, 32'h0, 1, 17);

        // Reset while WRITE is held by waitrequest
        issue(OP_SB, 32'h0000_6001, 32'h0000_0077, 32'h0102_0304, 0, 5, 1, 32'h0102_7704, 0, 8);
        n = 0;
        while (!mem_write && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reach_write", {31'b0, mem_write}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        #3;
        chk("rstw_write", {31'b0, mem_write}, 32'd0);
        chk("rstw_read",  {31'b0, mem_read},  32'd0);
        chk("rstw_stall", {31'b0, stall},     32'd0);
        chk("rstw_done",  {31'b0, done},      32'd0);
        chk("rstw_addr",  mem_address,        32'd0);
        chk("rstw_lost",  32'(sb.size()),     32'd2);
        sb.delete();
        reset = 1'b0;
        run(OP_SB, 32'h0000_5000, 32'h0000_00C3, 32'h0000_0000, 0, 0, 1, 32'h0000_00C3, 0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
